// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-channel TDM receive path: channel geometry and
// the framing FSM state type.
package tdm_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Per-beat capture decision produced by the framing logic.
  typedef struct packed {
    logic            en;
    logic [CH_W-1:0] sel;
    logic            fv;
    logic            fe;
  } cap_t;

  function automatic logic last_ch(input logic [CH_W-1:0] s);
    return s == CH_W'(NUM_CH - 1);
  endfunction

endpackage

// File: rtl/demux_1_to_4.sv
// 1-to-4 enable demux: routes a single enable onto the one-hot line picked by sel.
module demux_1_to_4
  import tdm_pkg::*;
(
  input  logic              en,
  input  logic [CH_W-1:0]   sel,
  output logic [NUM_CH-1:0] oh
);

  always_comb begin
    oh = '0;
    if (en) oh[sel] = 1'b1;
  end

endmodule

// File: rtl/tdm_demux_4ch.sv
// TDM receive demux: steers each bus beat into its channel register, flags
// completed frames and frames aborted by an early sof.
module tdm_demux_4ch
  import tdm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [3:0]       ch_strobe,
  output logic             frame_valid,
  output logic             frame_err,
  output logic [1:0]       ch_sel
);

  state_t                         state;
  logic [CH_W-1:0]                sel_q;
  logic [NUM_CH-1:0][WIDTH-1:0]   y_q;
  cap_t                           cap;
  logic [NUM_CH-1:0]              cap_oh;

  // sof always re-anchors on channel 0; a non-sof beat only lands while in a frame.
  always_comb begin
    cap = '0;
    if (din_valid) begin
      if (sof) begin
        cap.en  = 1'b1;
        cap.sel = '0;
        cap.fe  = (state == RUN);
      end else if (state == RUN) begin
        cap.en  = 1'b1;
        cap.sel = sel_q;
        cap.fv  = last_ch(sel_q);
      end
    end
  end

  demux_1_to_4 u_demux (
    .en  (cap.en),
    .sel (cap.sel),
    .oh  (cap_oh)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sel_q       <= '0;
      ch_strobe   <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      ch_strobe   <= cap_oh;
      frame_valid <= cap.fv;
      frame_err   <= cap.fe;
      if (din_valid) begin
        case (state)
          IDLE: if (sof) begin
            sel_q <= CH_W'(1);
            state <= RUN;
          end
          RUN: if (sof) begin
            sel_q <= CH_W'(1);
          end else begin
            // channel 3 wraps sel_q back to 0 for the next frame
            sel_q <= sel_q + 1'b1;
            if (last_ch(sel_q)) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         y_q[i] <= '0;
      else if (cap_oh[i]) y_q[i] <= din;
    end
  end

  assign y0     = y_q[0];
  assign y1     = y_q[1];
  assign y2     = y_q[2];
  assign y3     = y_q[3];
  assign ch_sel = sel_q;

endmodule
